link_spi_sequencer: RTL and testbench
=====================================

Name: link_spi_sequencer

Overview:
- Master-side controller for the SPI link control bus. Consumes decoder status (command, address, size, start/end/error strobes) and sequences the encoder (out_enable, out_cmd_code, out_addr, out_data_size) to produce replies.
- Sits between the SPI link and the bridge core. Decides per received packet whether to reply with data, reply with status, or stay silent, and keeps sticky error/overflow status.

Parameters:
- OWN_ADDR, 8'h01, service-protocol address of this bridge; packets for other addresses are ignored.
- CMD_SEND, 8'hA1, command code: data to forward (no reply).
- CMD_RECEIVE, 8'hA2, command code: host requests queued data.
- CMD_STATUS, 8'hA3, command code: host requests status word.
- CMD_RESET, 8'hA4, command code: clear sticky status.
- CMD_DATA, 8'hB1, reply code for a data reply.
- CMD_STAT_REPLY, 8'hB2, reply code for a status reply.
- TIMEOUT_CYCLES, 4096, reply watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_cmd_code  in  8  decoded command code
- in_addr  in  8  decoded packet address
- in_size  in  16  decoded packet data size (words)
- in_packet_start  in  1  decoder start strobe (1 cycle)
- in_packet_end  in  1  decoder good-end strobe (1 cycle)
- in_packet_err  in  1  decoder error strobe (1 cycle)
- spi_is_busy  in  1  SPI transaction in progress
- out_queue_overflow  in  1  SPI transmit queue overflow
- in_queue_overflow  in  1  SPI receive queue overflow
- tx_avail  in  16  words currently available in the pop queue feeding the encoder
- tx_done  in  1  encoder finished the current reply (1-cycle strobe)
- out_enable  out  1  encoder enable
- out_cmd_code  out  8  reply command code
- out_addr  out  8  reply address
- out_data_size  out  16  reply payload size (words)
- status_word  out  16  {err_cnt[7:0], 4'b0, timeout_flag, ovf_in, ovf_out, busy}
- err_cnt  out  8  count of decoder errors, saturating at 8'hFF

Behaviour:
- Reset values: out_enable=0, out_cmd_code=0, out_addr=0, out_data_size=0, err_cnt=0, sticky flags=0, state=IDLE.
- States and transitions:
  - IDLE: in_packet_start -> RX.
  - RX: in_packet_err -> IDLE, err_cnt+1 (saturating). in_packet_end -> latch cmd/addr/size, go to DECIDE.
  - DECIDE (1 cycle):
    - addr != OWN_ADDR -> IDLE.
    - CMD_SEND -> IDLE.
    - CMD_RESET -> clear err_cnt and sticky flags, then IDLE.
    - CMD_RECEIVE -> REPLY with out_data_size = min(latched size, tx_avail). If that value is 0 -> IDLE with no reply.
    - CMD_STATUS -> REPLY with out_data_size=1, code CMD_STAT_REPLY.
    - Unknown code -> err_cnt+1, IDLE.
  - REPLY: wait for spi_is_busy=0, then assert out_enable. Hold out_enable and the reply fields stable until tx_done, then deassert out_enable and go to IDLE.
- Latency: out_enable rises exactly 2 cycles after in_packet_end when spi_is_busy=0 (registered DECIDE plus registered output).
- out_addr is always OWN_ADDR during a reply. status_word is sampled into the reply only while out_enable=1.
- Sticky flags ovf_in and ovf_out are set on any cycle their input is high and cleared only by rst or CMD_RESET. A set in the same cycle as a CMD_RESET clear wins.
- busy bit = (state != IDLE), combinational from the state register.
- in_packet_start while in RX: restart RX and count one error (lost packet end).
- Start or end strobes in DECIDE or REPLY are ignored. A decoder error in REPLY still increments err_cnt.
- in_packet_end and in_packet_err in the same cycle: error wins.
- rst mid-reply: out_enable drops the same edge and all state clears.

Optional Feature:
- Macro LINK_SPI_SEQ_TIMEOUT_EN.
- When defined: a 16-bit counter runs in REPLY while out_enable=1. On reaching TIMEOUT_CYCLES-1 without tx_done, deassert out_enable, set sticky timeout_flag, err_cnt+1, return to IDLE.
- When undefined: no counter, timeout_flag is tied to 0, and REPLY waits indefinitely for tx_done.

Test Plan:
- STATUS to OWN_ADDR, spi_is_busy=0, err_cnt=3 -> out_enable high 2 cycles after end; code 8'hB2, size 1, addr 8'h01; status_word[15:8]=3; drops the cycle after tx_done.
- RECEIVE size 10, tx_avail 4 -> out_data_size=4, code 8'hB1. Repeat with tx_avail 0 -> no out_enable pulse.
- RECEIVE with addr 8'h07 -> no reply, state back in IDLE within 2 cycles. SEND to OWN_ADDR -> no reply.
- 300 in_packet_err strobes -> err_cnt saturates at 8'hFF. Then CMD_RESET -> err_cnt=0. Pulse in_queue_overflow in the same cycle as the reset clear -> ovf_in=1.
- STATUS while spi_is_busy=1 for 20 cycles -> out_enable stays 0 until the cycle after busy falls. Assert rst during REPLY -> out_enable=0 next edge, all outputs at reset values.
- With LINK_SPI_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: reply with no tx_done -> out_enable high exactly 16 cycles, then timeout_flag=1 and err_cnt+1.

Source files
------------

// File: rtl/link_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : link_spi_sequencer
// Description : Master-side sequencer for the SPI link control bus. Watches
//               decoder strobes, decides per packet whether to send a data
//               reply, a status reply or nothing, drives the encoder and
//               keeps sticky error/overflow status.
//               Optional reply watchdog: define LINK_SPI_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module link_spi_sequencer #(
    parameter logic [7:0] OWN_ADDR       = 8'h01,
    parameter logic [7:0] CMD_SEND       = 8'hA1,
    parameter logic [7:0] CMD_RECEIVE    = 8'hA2,
    parameter logic [7:0] CMD_STATUS     = 8'hA3,
    parameter logic [7:0] CMD_RESET      = 8'hA4,
    parameter logic [7:0] CMD_DATA       = 8'hB1,
    parameter logic [7:0] CMD_STAT_REPLY = 8'hB2,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_cmd_code,
    input  logic [7:0]  in_addr,
    input  logic [15:0] in_size,
    input  logic        in_packet_start,
    input  logic        in_packet_end,
    input  logic        in_packet_err,
    input  logic        spi_is_busy,
    input  logic        out_queue_overflow,
    input  logic        in_queue_overflow,
    input  logic [15:0] tx_avail,
    input  logic        tx_done,
    output logic        out_enable,
    output logic [7:0]  out_cmd_code,
    output logic [7:0]  out_addr,
    output logic [15:0] out_data_size,
    output logic [15:0] status_word,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RX     = 2'd1,
        ST_DECIDE = 2'd2,
        ST_REPLY  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    // Packet fields captured on a good end strobe
    logic [7:0]  r_cmd;
    logic [7:0]  r_addr;
    logic [15:0] r_size;

    // Encoder-facing registers
    logic        r_enable;
    logic [7:0]  r_cmd_code;
    logic [7:0]  r_reply_addr;
    logic [15:0] r_data_size;
    logic [7:0]  r_err_cnt;

    // Sticky status
    logic        r_ovf_in;
    logic        r_ovf_out;
    logic        r_timeout;

    // Next-state values from the decision logic
    logic        w_enable_nx;
    logic [7:0]  w_cmd_code_nx;
    logic [7:0]  w_reply_addr_nx;
    logic [15:0] w_data_size_nx;
    logic        w_latch;
    logic        w_extra_err;
    logic        w_clear;
    logic        w_timeout_set;
    logic        w_timeout_hit;
    logic [15:0] w_min_size;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic [7:0]  w_err_nx;

    assign w_min_size = (r_size < tx_avail) ? r_size : tx_avail;

`ifdef LINK_SPI_SEQ_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // Watchdog counts cycles spent with the encoder enabled
    always_ff @(posedge clk) begin
        if (rst || !((r_state == ST_REPLY) && r_enable)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_timeout_hit = (r_state == ST_REPLY) && r_enable && !tx_done &&
                           (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Next-state and reply-field decisions
    always_comb begin
        w_state_nx      = r_state;
        w_enable_nx     = r_enable;
        w_cmd_code_nx   = r_cmd_code;
        w_reply_addr_nx = r_reply_addr;
        w_data_size_nx  = r_data_size;
        w_latch         = 1'b0;
        w_extra_err     = 1'b0;
        w_clear         = 1'b0;
        w_timeout_set   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (in_packet_start) begin
                    w_state_nx = ST_RX;
                end
            end
            ST_RX: begin
                // Error strobe takes priority over both start and end
                if (in_packet_err) begin
                    w_state_nx = ST_IDLE;
                end else if (in_packet_start) begin
                    // A new start without an end means a packet was lost
                    w_state_nx  = ST_RX;
                    w_extra_err = 1'b1;
                end else if (in_packet_end) begin
                    w_latch    = 1'b1;
                    w_state_nx = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                w_state_nx = ST_IDLE;
                if (r_addr == OWN_ADDR) begin
                    case (r_cmd)
                        CMD_SEND: begin
                            w_state_nx = ST_IDLE;
                        end
                        CMD_RESET: begin
                            w_clear = 1'b1;
                        end
                        CMD_RECEIVE: begin
                            if (w_min_size != 16'd0) begin
                                w_state_nx      = ST_REPLY;
                                w_cmd_code_nx   = CMD_DATA;
                                w_reply_addr_nx = OWN_ADDR;
                                w_data_size_nx  = w_min_size;
                                w_enable_nx     = !spi_is_busy;
                            end
                        end
                        CMD_STATUS: begin
                            w_state_nx      = ST_REPLY;
                            w_cmd_code_nx   = CMD_STAT_REPLY;
                            w_reply_addr_nx = OWN_ADDR;
                            w_data_size_nx  = 16'd1;
                            w_enable_nx     = !spi_is_busy;
                        end
                        default: begin
                            w_extra_err = 1'b1;
                        end
                    endcase
                end
            end
            ST_REPLY: begin
                if (!r_enable) begin
                    if (!spi_is_busy) begin
                        w_enable_nx = 1'b1;
                    end
                end else if (tx_done) begin
                    w_enable_nx = 1'b0;
                    w_state_nx  = ST_IDLE;
                end else if (w_timeout_hit) begin
                    w_enable_nx   = 1'b0;
                    w_timeout_set = 1'b1;
                    w_extra_err   = 1'b1;
                    w_state_nx    = ST_IDLE;
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_enable_nx = 1'b0;
            end
        endcase
    end

    // Decoder errors count in every state; extra events add on top, saturating
    assign w_err_inc = {1'b0, in_packet_err} + {1'b0, w_extra_err};
    assign w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_err_inc};
    assign w_err_nx  = w_clear ? 8'd0 : (w_err_sum[8] ? 8'hFF : w_err_sum[7:0]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Encoder outputs, captured packet fields and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd        <= '0;
            r_addr       <= '0;
            r_size       <= '0;
            r_enable     <= 1'b0;
            r_cmd_code   <= '0;
            r_reply_addr <= '0;
            r_data_size  <= '0;
            r_err_cnt    <= '0;
            r_ovf_in     <= 1'b0;
            r_ovf_out    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_latch) begin
                r_cmd  <= in_cmd_code;
                r_addr <= in_addr;
                r_size <= in_size;
            end
            r_enable     <= w_enable_nx;
            r_cmd_code   <= w_cmd_code_nx;
            r_reply_addr <= w_reply_addr_nx;
            r_data_size  <= w_data_size_nx;
            r_err_cnt    <= w_err_nx;
            // A set in the same cycle as a clear leaves the flag set
            r_ovf_in     <= (r_ovf_in  & ~w_clear) | in_queue_overflow;
            r_ovf_out    <= (r_ovf_out & ~w_clear) | out_queue_overflow;
            r_timeout    <= (r_timeout & ~w_clear) | w_timeout_set;
        end
    end

    assign out_enable    = r_enable;
    assign out_cmd_code  = r_cmd_code;
    assign out_addr      = r_reply_addr;
    assign out_data_size = r_data_size;
    assign err_cnt       = r_err_cnt;
    assign status_word   = {r_err_cnt, 4'b0000, r_timeout, r_ovf_in, r_ovf_out,
                            (r_state != ST_IDLE)};

endmodule
`default_nettype wire

// File: tb/tb_link_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_spi_sequencer
// Description : Self-checking bench for link_spi_sequencer with a packet-level
//               reference model of replies and sticky status.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_spi_sequencer;

    localparam logic [7:0] OWN  = 8'h01;
    localparam logic [7:0] SEND = 8'hA1;
    localparam logic [7:0] RECV = 8'hA2;
    localparam logic [7:0] STAT = 8'hA3;
    localparam logic [7:0] RSET = 8'hA4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_cmd_code = '0;
    logic [7:0]  in_addr = '0;
    logic [15:0] in_size = '0;
    logic        in_packet_start = 1'b0;
    logic        in_packet_end = 1'b0;
    logic        in_packet_err = 1'b0;
    logic        spi_is_busy = 1'b0;
    logic        out_queue_overflow = 1'b0;
    logic        in_queue_overflow = 1'b0;
    logic [15:0] tx_avail = '0;
    logic        tx_done = 1'b0;
    logic        out_enable;
    logic [7:0]  out_cmd_code;
    logic [7:0]  out_addr;
    logic [15:0] out_data_size;
    logic [15:0] status_word;
    logic [7:0]  err_cnt;

    link_spi_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .in_cmd_code(in_cmd_code), .in_addr(in_addr), .in_size(in_size),
        .in_packet_start(in_packet_start), .in_packet_end(in_packet_end),
        .in_packet_err(in_packet_err), .spi_is_busy(spi_is_busy),
        .out_queue_overflow(out_queue_overflow), .in_queue_overflow(in_queue_overflow),
        .tx_avail(tx_avail), .tx_done(tx_done),
        .out_enable(out_enable), .out_cmd_code(out_cmd_code), .out_addr(out_addr),
        .out_data_size(out_data_size), .status_word(status_word), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_err = 0;
    bit m_ovf_in = 1'b0;
    bit m_ovf_out = 1'b0;
    bit m_to = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [15:0] exp_status(input bit busy);
        logic [7:0] e;
        e = m_err[7:0];
        return {e, 4'b0000, m_to, m_ovf_in, m_ovf_out, busy};
    endfunction

    // kind: 0 = silent, 1 = data reply, 2 = status reply
    function automatic void model_reply(input logic [7:0] cmd, input logic [7:0] addr,
                                        input int size, input int avail,
                                        output int kind, output int rsize);
        kind  = 0;
        rsize = 0;
        if (addr == OWN) begin
            if (cmd == RECV) begin
                rsize = (size < avail) ? size : avail;
                kind  = (rsize > 0) ? 1 : 0;
            end else if (cmd == STAT) begin
                kind  = 2;
                rsize = 1;
            end
        end
    endfunction

    // Decide-cycle side effects on sticky status
    task automatic model_decide(input logic [7:0] cmd, input logic [7:0] addr);
        if (addr == OWN) begin
            if (cmd == RSET) begin
                m_err = 0; m_ovf_in = 0; m_ovf_out = 0; m_to = 0;
            end else if (cmd != SEND && cmd != RECV && cmd != STAT) begin
                m_err = sat(m_err + 1);
            end
        end
    endtask

    // One full packet; leave_open returns with the reply still enabled
    task automatic run_packet(input logic [7:0] cmd, input logic [7:0] addr,
                              input int size, input int avail, input int bcyc,
                              input int hold, input bit ovf_dec, input int err_at,
                              input bit leave_open);
        int kind, rsize;
        model_reply(cmd, addr, size, avail, kind, rsize);
        in_packet_start = 1'b1; tick(); in_packet_start = 1'b0;
        in_cmd_code = cmd; in_addr = addr; in_size = 16'(size); tx_avail = 16'(avail);
        spi_is_busy = (bcyc > 0);
        in_packet_end = 1'b1; tick(); in_packet_end = 1'b0;
        check("decide_en", out_enable, 0);
        if (ovf_dec) in_queue_overflow = 1'b1;
        tick();
        in_queue_overflow = 1'b0;
        model_decide(cmd, addr);
        if (ovf_dec) m_ovf_in = 1'b1;
        if (kind == 0) begin
            check("noreply_en", out_enable, 0);
            check("noreply_status", status_word, exp_status(1'b0));
            spi_is_busy = 1'b0;
        end else begin
            if (bcyc > 0) begin
                for (int i = 0; i < bcyc; i++) begin
                    check("busy_wait_en", out_enable, 0);
                    tick();
                end
                spi_is_busy = 1'b0;
                check("busy_last_en", out_enable, 0);
                tick();
            end
            check("reply_en", out_enable, 1);
            check("reply_code", out_cmd_code, (kind == 1) ? 8'hB1 : 8'hB2);
            check("reply_addr", out_addr, OWN);
            check("reply_size", out_data_size, rsize);
            check("reply_status", status_word, exp_status(1'b1));
            if (!leave_open) begin
                for (int i = 0; i < hold; i++) begin
                    if (i == err_at) in_packet_err = 1'b1;
                    tick();
                    if (i == err_at) begin
                        in_packet_err = 1'b0;
                        m_err = sat(m_err + 1);
                        check("reply_err_cnt", err_cnt, m_err);
                    end
                    check("hold_en", out_enable, 1);
                    check("hold_size", out_data_size, rsize);
                end
                tx_done = 1'b1; tick(); tx_done = 1'b0;
                check("done_en", out_enable, 0);
                check("done_status", status_word, exp_status(1'b0));
            end
        end
    endtask

    task automatic err_packet(input bit with_end);
        in_packet_start = 1'b1; tick(); in_packet_start = 1'b0;
        in_cmd_code = STAT; in_addr = OWN;
        in_packet_err = 1'b1; in_packet_end = with_end;
        tick();
        in_packet_err = 1'b0; in_packet_end = 1'b0;
        m_err = sat(m_err + 1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        check("rst_en", out_enable, 0);
        check("rst_code", out_cmd_code, 0);
        check("rst_addr", out_addr, 0);
        check("rst_size", out_data_size, 0);
        check("rst_err", err_cnt, 0);
        check("rst_status", status_word, 16'h0000);

        // Three decoder errors, then a status reply showing them
        for (int i = 0; i < 3; i++) err_packet(1'b0);
        check("err3", err_cnt, 3);
        run_packet(STAT, OWN, 5, 0, 0, 2, 1'b0, -1, 1'b0);

        // Data replies limited by queue contents
        run_packet(RECV, OWN, 10, 4, 0, 1, 1'b0, -1, 1'b0);
        run_packet(RECV, OWN, 10, 0, 0, 0, 1'b0, -1, 1'b0);
        run_packet(RECV, OWN, 3, 9, 1, 0, 1'b0, -1, 1'b0);

        // Foreign address, SEND and unknown codes stay silent
        run_packet(RECV, 8'h07, 10, 4, 0, 0, 1'b0, -1, 1'b0);
        run_packet(SEND, OWN, 10, 4, 0, 0, 1'b0, -1, 1'b0);
        run_packet(8'h55, OWN, 1, 1, 0, 0, 1'b0, -1, 1'b0);
        check("unknown_err", err_cnt, m_err);

        // End and error together: error wins, no reply follows
        err_packet(1'b1);
        tick(); tick();
        check("enderr_en", out_enable, 0);
        check("enderr_status", status_word, exp_status(1'b0));

        // Restart inside RX counts a lost packet and still completes
        in_packet_start = 1'b1; tick(); tick(); in_packet_start = 1'b0;
        m_err = sat(m_err + 1);
        check("restart_err", err_cnt, m_err);
        in_cmd_code = STAT; in_addr = OWN;
        in_packet_end = 1'b1; tick(); in_packet_end = 1'b0;
        tick();
        check("restart_reply_en", out_enable, 1);
        tx_done = 1'b1; tick(); tx_done = 1'b0;

        // Saturation, then reset command with a simultaneous overflow set
        for (int i = 0; i < 300; i++) err_packet(1'b0);
        check("err_sat", err_cnt, 8'hFF);
        run_packet(RSET, OWN, 0, 0, 0, 0, 1'b1, -1, 1'b0);
        check("reset_err", err_cnt, 0);
        check("reset_ovf_in", status_word[2], 1);

        // Long busy period before the reply may start
        run_packet(STAT, OWN, 0, 0, 20, 1, 1'b0, -1, 1'b0);

        // Decoder error while replying
        run_packet(RECV, OWN, 7, 7, 0, 4, 1'b0, 1, 1'b0);

        // Randomized packets against the model
        for (int n = 0; n < 40; n++) begin
            logic [7:0] c, a;
            int pick;
            if ($urandom_range(0, 3) == 0) begin
                out_queue_overflow = 1'b1; tick(); out_queue_overflow = 1'b0;
                m_ovf_out = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                err_packet(1'b0);
                check("rand_err_cnt", err_cnt, m_err);
            end
            pick = $urandom_range(0, 5);
            case (pick)
                0: c = SEND;
                1: c = RECV;
                2: c = RECV;
                3: c = STAT;
                4: c = RSET;
                default: c = 8'($urandom_range(0, 255));
            endcase
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : OWN;
            run_packet(c, a, $urandom_range(0, 12), $urandom_range(0, 12),
                       $urandom_range(0, 3), $urandom_range(0, 5),
                       ($urandom_range(0, 4) == 0), -1, 1'b0);
            check("rand_err_cnt_end", err_cnt, m_err);
        end

`ifdef LINK_SPI_SEQ_TIMEOUT_EN
        // Reply with no completion is cut off by the watchdog
        begin
            int high;
            run_packet(STAT, OWN, 0, 0, 0, 0, 1'b0, -1, 1'b1);
            high = 1;
            for (int i = 0; i < 40 && out_enable; i++) begin
                tick();
                if (out_enable) high++;
            end
            m_err = sat(m_err + 1);
            m_to  = 1'b1;
            check("timeout_len", high, 16);
            check("timeout_status", status_word, exp_status(1'b0));
        end
`endif

        // Reset in the middle of a reply
        run_packet(RECV, OWN, 6, 5, 0, 0, 1'b0, -1, 1'b1);
        rst = 1'b1; tick();
        check("midrst_en", out_enable, 0);
        check("midrst_code", out_cmd_code, 0);
        check("midrst_addr", out_addr, 0);
        check("midrst_size", out_data_size, 0);
        check("midrst_status", status_word, 16'h0000);
        rst = 1'b0;
        m_err = 0; m_ovf_in = 0; m_ovf_out = 0; m_to = 0;
        run_packet(STAT, OWN, 0, 0, 0, 1, 1'b0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
